busca_instrucao: RTL and testbench



---
 rtl/busca_instrucao.sv | 103 ++++++++++
 tb/tb_busca_instrucao.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: holds the PC, registers the word returned by instruction memory and
// hands it to decode over valid/ready, with redirect, misalignment halt and EBREAK halt.
module busca_instrucao #(
  parameter int unsigned           BITS     = 8,
  parameter int unsigned           DEPTH    = 128,
  parameter int unsigned           ADDR_W   = 7,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ADDR_W-1:0]   endr,
  input  logic [BITS*4-1:0]   instr_in,
  input  logic                desvio,
  input  logic [ADDR_W-1:0]   alvo,
  output logic [BITS*4-1:0]   instr_out,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                valid,
  input  logic                ready,
  output logic                parado,
  output logic                erro_alinhamento,
  output logic [15:0]         contador
);

  localparam logic [BITS*4-1:0] Ebreak = (BITS*4)'(32'h0010_0073);

  typedef enum logic [1:0] {StInicio, StBusca, StParado} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [BITS*4-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic                valid_q, valid_d;
  logic                erro_q, erro_d;
  logic [15:0]         cont_q, cont_d;
  logic                handshake;

  assign handshake = valid_q & ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    erro_d   = erro_q;
    // Counts handshakes in every state, including one that coincides with a redirect.
    cont_d   = handshake ? cont_q + 16'd1 : cont_q;

    unique case (state_q)
      StInicio: state_d = StBusca;
      StBusca: begin
        if (desvio && (alvo[1:0] != 2'b00)) begin
          erro_d  = 1'b1;
          valid_d = 1'b0;
          state_d = StParado;
        end else if (desvio) begin
          pc_d    = alvo;
          valid_d = 1'b0;
        end else if (!valid_q || ready) begin
          instr_d  = instr_in;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + ADDR_W'(4);
          if (instr_in == Ebreak) state_d = StParado;
        end
      end
      StParado: begin
        // Only drain what is already held; no fetch, redirects ignored.
        if (handshake) valid_d = 1'b0;
      end
      default: state_d = StInicio;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StInicio;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      erro_q   <= 1'b0;
      cont_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      erro_q   <= erro_d;
      cont_q   <= cont_d;
    end
  end

  assign endr             = pc_q;
  assign instr_out        = instr_q;
  assign pc_out           = pc_out_q;
  assign valid            = valid_q;
  assign parado           = (state_q == StParado);
  assign erro_alinhamento = erro_q;
  assign contador         = cont_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: byte-array memory model plus a scoreboard of expected
// (pc, instruction) beats popped on every handshake.
module tb_busca_instrucao;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  endr;
  logic [31:0] instr_in;
  logic        desvio = 1'b0;
  logic [6:0]  alvo = '0;
  logic [31:0] instr_out;
  logic [6:0]  pc_out;
  logic        valid;
  logic        ready = 1'b0;
  logic        parado;
  logic        erro_alinhamento;
  logic [15:0] contador;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  beat_t       sb_q[$];
  logic [7:0]  mem [128];
  int          n_checks = 0;
  int          n_errors = 0;

  busca_instrucao dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .endr             (endr),
    .instr_in         (instr_in),
    .desvio           (desvio),
    .alvo             (alvo),
    .instr_out        (instr_out),
    .pc_out           (pc_out),
    .valid            (valid),
    .ready            (ready),
    .parado           (parado),
    .erro_alinhamento (erro_alinhamento),
    .contador         (contador)
  );

  always #5 clk = ~clk;

  // Combinational little-endian word read at endr.
  always_comb begin
    int a;
    a = int'(endr);
    instr_in = {mem[(a + 3) % 128], mem[(a + 2) % 128], mem[(a + 1) % 128], mem[a % 128]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input int addr, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[addr + i] = w[8*i +: 8];
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] w);
    beat_t b;
    b.pc = pc;
    b.instr = w;
    sb_q.push_back(b);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_valid"}, 32'(valid), 32'd0);
    check_eq({tag, "_instr"}, instr_out, 32'd0);
    check_eq({tag, "_pc_out"}, 32'(pc_out), 32'd0);
    check_eq({tag, "_parado"}, 32'(parado), 32'd0);
    check_eq({tag, "_erro"}, 32'(erro_alinhamento), 32'd0);
    check_eq({tag, "_cont"}, 32'(contador), 32'd0);
    check_eq({tag, "_endr"}, 32'(endr), 32'd0);
  endtask

  // Handshake monitor: valid & ready seen before the rising edge means a delivery on that edge.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_beat", 32'(pc_out), 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = sb_q.pop_front();
        check_eq("sb_pc", 32'(pc_out), e.pc);
        check_eq("sb_instr", instr_out, e.instr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    put_word(0, 32'h0DB0_0000);
    put_word(4, 32'h3EA0_0000);
    put_word(8, 32'h1111_1111);
    put_word(12, 32'h2222_2222);
    put_word(8'h40, 32'h4444_4444);
    put_word(8'h44, 32'h5555_5555);
    put_word(8'h7C, 32'h0010_0073);

    #2 rst_n = 1'b0;
    #10;
    check_reset_values("rst");

    // Stream with ready=1
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    push(0, 32'h0DB0_0000);
    push(4, 32'h3EA0_0000);
    push(8, 32'h1111_1111);
    ready = 1'b1;
    tick;
    check_eq("inicio_no_fetch", 32'(valid), 32'd0);
    tick;
    tick;
    tick;
    ready = 1'b0;
    check_eq("stream_cont", 32'(contador), 32'd2);
    check_eq("stream_valid", 32'(valid), 32'd1);

    // Backpressure: held beat must not move
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_instr", instr_out, 32'h1111_1111);
      check_eq("bp_pc_out", 32'(pc_out), 32'd8);
      check_eq("bp_endr", 32'(endr), 32'd12);
      tick;
    end
    check_eq("bp_cont_hold", 32'(contador), 32'd2);
    ready = 1'b1;
    tick;
    check_eq("bp_cont_inc", 32'(contador), 32'd3);
    check_eq("bp_next_pc", 32'(pc_out), 32'd12);

    // Redirect during a beat that is also handed off
    push(12, 32'h2222_2222);
    desvio = 1'b1;
    alvo = 7'h40;
    tick;
    desvio = 1'b0;
    check_eq("redir_valid", 32'(valid), 32'd0);
    check_eq("redir_cont", 32'(contador), 32'd4);
    check_eq("redir_endr", 32'(endr), 32'h40);
    push(32'h40, 32'h4444_4444);
    tick;
    check_eq("redir_pc_out", 32'(pc_out), 32'h40);

    // Misaligned target
    desvio = 1'b1;
    alvo = 7'h42;
    tick;
    alvo = 7'h10;
    check_eq("mis_erro", 32'(erro_alinhamento), 32'd1);
    check_eq("mis_parado", 32'(parado), 32'd1);
    check_eq("mis_valid", 32'(valid), 32'd0);
    check_eq("mis_endr", 32'(endr), 32'h44);
    check_eq("mis_cont", 32'(contador), 32'd5);
    tick;
    tick;
    desvio = 1'b0;
    check_eq("mis_endr_frozen", 32'(endr), 32'h44);
    check_eq("mis_erro_sticky", 32'(erro_alinhamento), 32'd1);
    check_eq("mis_still_idle", 32'(valid), 32'd0);
    check_eq("mis_sb_empty", 32'(sb_q.size()), 32'd0);

    // Async reset between edges clears the flags
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("arst1");

    // EBREAK at the top of memory, PC wraps to 0
    tick;
    rst_n = 1'b1;
    ready = 1'b0;
    tick;
    desvio = 1'b1;
    alvo = 7'h7C;
    tick;
    desvio = 1'b0;
    check_eq("ebk_endr", 32'(endr), 32'h7C);
    tick;
    check_eq("ebk_valid", 32'(valid), 32'd1);
    check_eq("ebk_instr", instr_out, 32'h0010_0073);
    check_eq("ebk_parado", 32'(parado), 32'd1);
    check_eq("ebk_endr_wrap", 32'(endr), 32'd0);
    push(32'h7C, 32'h0010_0073);
    ready = 1'b1;
    tick;
    check_eq("ebk_drained", 32'(valid), 32'd0);
    check_eq("ebk_cont", 32'(contador), 32'd1);
    tick;
    tick;
    check_eq("ebk_no_fetch", 32'(valid), 32'd0);
    check_eq("ebk_endr_frozen", 32'(endr), 32'd0);
    check_eq("ebk_sb_empty", 32'(sb_q.size()), 32'd0);

    // Async reset mid-stream, then restart at RESET_PC
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    push(0, 32'h0DB0_0000);
    tick;
    tick;
    tick;
    check_eq("ms_pc_out", 32'(pc_out), 32'd4);
    check_eq("ms_instr", instr_out, 32'h3EA0_0000);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("arst2");
    tick;
    rst_n = 1'b1;
    push(0, 32'h0DB0_0000);
    tick;
    tick;
    check_eq("restart_valid", 32'(valid), 32'd1);
    check_eq("restart_pc_out", 32'(pc_out), 32'd0);
    tick;
    ready = 1'b0;
    check_eq("restart_next", 32'(pc_out), 32'd4);
    check_eq("restart_cont", 32'(contador), 32'd1);
    tick;
    check_eq("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
